systolic_nxn: RTL and testbench
===============================

Name: systolic_nxn

Overview:
- NxN output-stationary systolic matrix-multiply engine with its own read sequencer.
- Streams K column vectors of A and K row vectors of B from an external synchronous 8K x 32 SRAM (shared read port, 1-cycle read latency).
- Accumulates C = A x B in a grid of signed MAC processing elements (PEs) and exposes all NxN accumulators in parallel.
- Sits between the on-chip SRAM and the host controller, which pulses start and waits for done.

Parameters:
- N, 4, array dimension. Legal range 1..4 (N*8 <= 32).
- A_BASE, 13'h000, SRAM word address of A vector 0.
- B_BASE, 13'h100, SRAM word address of B vector 0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active low.
- start  in  1  launch request, sampled in IDLE only.
- clear  in  1  synchronous zeroing of all accumulators.
- k_param  in  8  inner dimension K (number of A/B vector pairs).
- data_a  in  32  SRAM read data, interpreted as an A vector.
- data_b  in  32  SRAM read data, interpreted as a B vector (may share wires with data_a).
- addr  out  13  SRAM read address.
- rd_en_n  out  1  SRAM chip select, active low.
- done  out  1  one-cycle completion pulse.
- out  out  N x N x 20  accumulators; out[i][j] = C[i][j], signed two's complement.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, addr=0, rd_en_n=1, done=0.
  - All accumulators, skew and pipeline registers cleared to 0.
- Data packing:
  - data_a[8i+7:8i] = A[i][k], signed int8.
  - data_b[8j+7:8j] = B[k][j], signed int8.
  - Bits above 8N are ignored.
- FSM states: IDLE, RD_A, RD_B, DRAIN, DONE.
- IDLE:
  - rd_en_n=1.
  - start=1 with k_param>0 -> RD_A, k=0.
  - start=1 with k_param=0 -> DONE directly; no reads, out unchanged.
- RD_A: addr=A_BASE+k, rd_en_n=0 -> RD_B.
- RD_B:
  - addr=B_BASE+k, rd_en_n=0.
  - k++; if k<k_param -> RD_A, else -> DRAIN.
- Read capture (SRAM latency 1):
  - data_a is captured in the cycle after RD_A.
  - data_b is captured in the cycle after RD_B; that capture also loads the (a,b) pair into the launch register.
  - The launch register's valid flag is high for exactly that one cycle; otherwise it launches zeros.
- Skew and flow:
  - Row i input of A is delayed i cycles; column j input of B is delayed j cycles.
  - A operands shift right one PE per cycle; B operands shift down one PE per cycle.
  - Zero bubbles between pairs are required and harmless.
- PE(i,j): acc <= acc + a*b every cycle.
  - Signed 8x8 -> 16-bit product, sign-extended.
  - 20-bit accumulator wraps modulo 2^20; no saturation.
- Cycle timing (cycle 1 = first cycle after the edge that samples start):
  - Pair k is launched in cycle 2k+4.
  - PE(i,j) adds pair k at the end of cycle 2k+4+i+j.
- DRAIN:
  - rd_en_n=1, addr holds last value.
  - Lasts until all in-flight products are accumulated, then -> DONE.
- DONE:
  - done=1 for exactly one cycle, in cycle 2K+2N+1 (N=4, K=6 -> cycle 21); then -> IDLE.
  - out is final when done is high.
- out is driven directly from the accumulator registers and holds after done until clear, reset, or a new run.
- start does NOT zero accumulators, so successive runs accumulate. Tiling software asserts clear first.
- clear=1 in any state zeros all accumulators that cycle. Products arriving in later cycles still accumulate.
- clear and an accumulate in the same cycle: clear wins and the accumulator becomes 0.
- start outside IDLE is ignored. k_param is latched when start is accepted; later changes have no effect on the run.
- rst_n asserted mid-run aborts immediately to the reset state. No done is produced.

Test Plan:
- Reset: hold rst_n=0 for 30 ns -> out all 0, done=0, rd_en_n=1, addr=0; rst_n=1 with start=0 -> no reads.
- Identity: A=I4 at words 0..3, B at 0x100..0x103 with B[k][j]=k*4+j+1, K=4, pulse start -> out[i][j]=B[i][j]; done in cycle 17; address sequence 0,0x100,1,0x101,...
- Signed wrap: all A=B=-128, K=6, N=4 -> each out = 6*16384 = 98304 mod 2^20 = 98304; with K=64 -> 1048576 mod 2^20 = 0.
- Mixed signs: A row = {1,-1,2,-2}, B col = {3,3,-1,5}, K=6 -> out values match a reference software matrix multiply exactly; done in cycle 21.
- Accumulate/clear: run twice without clear -> outputs double; assert clear for one cycle between runs -> outputs equal a single run.
- Corner cases: k_param=0 with start -> done in cycle 1, no rd_en_n low; start during RD_A is ignored; rst_n low mid-run -> outputs 0, done never pulses.

Source files
------------

// File: rtl/systolic_nxn.sv
// NxN output-stationary systolic matrix multiplier with its own SRAM read sequencer.
// Alternating A/B vector reads feed a skewed launch register; signed MACs accumulate C = A x B.
module systolic_nxn #(
    parameter int          N      = 4,
    parameter logic [12:0] A_BASE = 13'h000,
    parameter logic [12:0] B_BASE = 13'h100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic [7:0]                k_param,
    input  logic [31:0]               data_a,
    input  logic [31:0]               data_b,
    output logic [12:0]               addr,
    output logic                      rd_en_n,
    output logic                      done,
    output logic [N-1:0][N-1:0][19:0] out
);

    typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     k_q, k_d;
    logic [7:0]     kmax_q, kmax_d;
    logic [3:0]     dc_q, dc_d;
    logic [12:0]    addr_last_q;
    logic           rd_a_d1_q, rd_b_d1_q;
    logic [8*N-1:0] a_cap_q, a_cap_d;
    logic [8*N-1:0] la_d, lb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            kmax_q      <= '0;
            dc_q        <= '0;
            addr_last_q <= '0;
            rd_a_d1_q   <= 1'b0;
            rd_b_d1_q   <= 1'b0;
            a_cap_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            kmax_q      <= kmax_d;
            dc_q        <= dc_d;
            addr_last_q <= addr;
            rd_a_d1_q   <= (state_q == S_RD_A);
            rd_b_d1_q   <= (state_q == S_RD_B);
            a_cap_q     <= a_cap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        kmax_d  = kmax_q;
        dc_d    = dc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kmax_d  = k_param;
                    k_d     = '0;
                    state_d = (k_param == 8'd0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: begin
                k_d = k_q + 8'd1;
                if (({1'b0, k_q} + 9'd1) < {1'b0, kmax_q}) begin
                    state_d = S_RD_A;
                end else begin
                    state_d = S_DRAIN;
                    dc_d    = '0;
                end
            end
            // The last pair needs 2N cycles to reach the far corner PE.
            S_DRAIN: begin
                dc_d = dc_q + 4'd1;
                if (dc_q == 4'(2 * N - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr    = addr_last_q;
        rd_en_n = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_RD_A: begin
                addr    = A_BASE + {5'b0, k_q};
                rd_en_n = 1'b0;
            end
            S_RD_B: begin
                addr    = B_BASE + {5'b0, k_q};
                rd_en_n = 1'b0;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // A is held until its B partner returns, then both launch together for one cycle.
    always_comb begin
        a_cap_d = rd_a_d1_q ? data_a[8*N-1:0] : a_cap_q;
        la_d    = rd_b_d1_q ? a_cap_q : '0;
        lb_d    = rd_b_d1_q ? data_b[8*N-1:0] : '0;
    end

    if (N < 4) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{data_a[31:8*N], data_b[31:8*N]};
    end

    for (genvar i = 0; i < N; i++) begin : g_askew
        logic signed [7:0] dl_q [0:i];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) dl_q[s] <= '0;
            end else begin
                dl_q[0] <= la_d[8*i +: 8];
                for (int s = 1; s <= i; s++) dl_q[s] <= dl_q[s-1];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_bskew
        logic signed [7:0] dl_q [0:j];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= j; s++) dl_q[s] <= '0;
            end else begin
                dl_q[0] <= lb_d[8*j +: 8];
                for (int s = 1; s <= j; s++) dl_q[s] <= dl_q[s-1];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [7:0]  a_in, b_in;
            logic signed [15:0] prod;
            logic [19:0]        acc_q, acc_d;

            if (j == 0) begin : g_ain
                assign a_in = g_askew[i].dl_q[i];
            end else begin : g_ain
                assign a_in = g_row[i].g_col[j-1].g_apass.a_q;
            end

            if (i == 0) begin : g_bin
                assign b_in = g_bskew[j].dl_q[j];
            end else begin : g_bin
                assign b_in = g_row[i-1].g_col[j].g_bpass.b_q;
            end

            if (j < N - 1) begin : g_apass
                logic signed [7:0] a_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) a_q <= '0;
                    else        a_q <= a_in;
                end
            end

            if (i < N - 1) begin : g_bpass
                logic signed [7:0] b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) b_q <= '0;
                    else        b_q <= b_in;
                end
            end

            always_comb begin
                prod  = a_in * b_in;
                acc_d = clear ? 20'd0 : acc_q + {{4{prod[15]}}, prod};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc_q <= '0;
                else        acc_q <= acc_d;
            end

            assign out[i][j] = acc_q;
        end
    end

endmodule

// File: tb/tb_systolic_nxn.sv
// Bench for systolic_nxn: SRAM model, address scoreboard, table-driven matmul runs
// and hand-written sequences for clear, k=0, ignored start and mid-run reset.
module tb_systolic_nxn;

    localparam int N = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic                      clear = 1'b0;
    logic [7:0]                k_param = 8'd0;
    logic [31:0]               rdata = 32'd0;
    logic [12:0]               addr;
    logic                      rd_en_n;
    logic                      done;
    logic [N-1:0][N-1:0][19:0] out;

    always #5 clk = ~clk;

    logic [31:0] mem [0:8191];
    always @(posedge clk) if (!rd_en_n) rdata <= mem[addr];

    systolic_nxn #(.N(N), .A_BASE(13'h000), .B_BASE(13'h100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .k_param(k_param),
        .data_a(rdata), .data_b(rdata), .addr(addr), .rd_en_n(rd_en_n),
        .done(done), .out(out)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [12:0] exp_q [$];
    int          am [4][64];
    int          bm [64][4];
    logic [19:0] cref [4][4];

    typedef struct {
        int          sel;
        int          k;
        int          exp_done;
        logic [19:0] exp_c00;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int pat_a(input int sel, input int i, input int k);
        int av [4] = '{1, -1, 2, -2};
        case (sel)
            0:       return (i == k) ? 1 : 0;
            1:       return -128;
            default: return av[(i + k) % 4];
        endcase
    endfunction

    function automatic int pat_b(input int sel, input int k, input int j);
        int bv [4] = '{3, 3, -1, 5};
        case (sel)
            0:       return k * 4 + j + 1;
            1:       return -128;
            default: return bv[(k + j) % 4];
        endcase
    endfunction

    task automatic fill(input int sel, input int kk);
        logic [31:0] wa, wb;
        for (int k = 0; k < kk; k++) begin
            wa = '0;
            wb = '0;
            for (int i = 0; i < N; i++) begin
                am[i][k] = pat_a(sel, i, k);
                bm[k][i] = pat_b(sel, k, i);
                wa[8*i +: 8] = 8'(am[i][k]);
                wb[8*i +: 8] = 8'(bm[k][i]);
            end
            mem[k]           = wa;
            mem[13'h100 + k] = wb;
        end
    endtask

    task automatic compute_ref(input int kk, input int mult);
        int s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < kk; k++) s += am[i][k] * bm[k][j];
                cref[i][j] = 20'(s * mult);
            end
    endtask

    task automatic zero_ref();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cref[i][j] = '0;
    endtask

    task automatic check_out(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s out[%0d][%0d]", tag, i, j), 32'(out[i][j]), 32'(cref[i][j]));
    endtask

    task automatic push_addrs(input int kk);
        for (int k = 0; k < kk; k++) begin
            exp_q.push_back(13'(k));
            exp_q.push_back(13'h100 + 13'(k));
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Cycle c is observed at the falling edge after the c-th rising edge following start.
    task automatic do_run(input logic [7:0] kp, input logic [7:0] kp_late, input int hold,
                          input int exp_done, input string tag);
        int          done_cyc;
        int          n_done;
        logic [12:0] e;
        done_cyc = 0;
        n_done   = 0;
        @(negedge clk);
        start   = 1'b1;
        k_param = kp;
        for (int c = 1; c <= exp_done + 6; c++) begin
            @(negedge clk);
            if (c == 1) k_param = kp_late;
            if (c >= hold) start = 1'b0;
            if (!rd_en_n) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s unexpected read c%0d", tag, c), 32'(rd_en_n), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s addr c%0d", tag, c), 32'(addr), 32'(e));
                end
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
        end
        check($sformatf("%s done cycle", tag), 32'(done_cyc), 32'(exp_done));
        check($sformatf("%s done count", tag), 32'(n_done), 32'd1);
        check($sformatf("%s reads left", tag), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n_done;
        for (int a = 0; a < 8192; a++) mem[a] = '0;

        tbl[0] = '{0, 4, 17, 20'd1};
        tbl[1] = '{1, 6, 21, 20'd98304};
        tbl[2] = '{1, 64, 137, 20'd0};
        tbl[3] = '{2, 6, 21, 20'hFFFF4};

        #12;
        zero_ref();
        check_out("reset");
        check("reset done", 32'(done), 32'd0);
        check("reset rd_en_n", 32'(rd_en_n), 32'd1);
        check("reset addr", 32'(addr), 32'd0);
        #18;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle no read", 32'(rd_en_n), 32'd1);
        end

        foreach (tbl[v]) begin
            pulse_clear();
            fill(tbl[v].sel, tbl[v].k);
            compute_ref(tbl[v].k, 1);
            push_addrs(tbl[v].k);
            do_run(8'(tbl[v].k), 8'(tbl[v].k), 1, tbl[v].exp_done, $sformatf("vec%0d", v));
            check($sformatf("vec%0d c00 const", v), 32'(out[0][0]), 32'(tbl[v].exp_c00));
            check_out($sformatf("vec%0d", v));
        end

        push_addrs(6);
        do_run(8'd6, 8'd6, 1, 21, "accum");
        compute_ref(6, 2);
        check_out("accum x2");

        pulse_clear();
        zero_ref();
        check_out("cleared");
        push_addrs(6);
        do_run(8'd6, 8'd6, 1, 21, "after clear");
        compute_ref(6, 1);
        check_out("after clear");

        do_run(8'd0, 8'd0, 1, 1, "k0");
        check_out("k0 unchanged");

        pulse_clear();
        fill(2, 2);
        compute_ref(2, 1);
        push_addrs(2);
        do_run(8'd2, 8'd5, 2, 13, "held start");
        check_out("held start");

        fill(2, 6);
        n_done = 0;
        @(negedge clk);
        start   = 1'b1;
        k_param = 8'd6;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 10) rst_n = 1'b0;
            if (c == 14) rst_n = 1'b1;
            if (done) n_done++;
            if (c == 11) begin
                zero_ref();
                check_out("midrst");
                check("midrst rd_en_n", 32'(rd_en_n), 32'd1);
                check("midrst addr", 32'(addr), 32'd0);
            end
            if (c > 14) check($sformatf("midrst no read c%0d", c), 32'(rd_en_n), 32'd1);
        end
        check("midrst done count", 32'(n_done), 32'd0);
        check_out("midrst after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
